// File: rtl/mux_arb_pkg.sv
// Shared constants for the two-source round-robin mux arbiter.
// State encodings are fixed so they can be probed from outside the FSM.
package mux_arb_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_A = 2'b01;
    localparam logic [1:0] GNT_B = 2'b10;

    localparam int DEF_WIDTH       = 2;
    localparam int DEF_HOLD_CYCLES = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = IDLE,
        ARB_GNT_A = GNT_A,
        ARB_GNT_B = GNT_B
    } arb_state_e;

endpackage

// File: rtl/mux2_w.sv
// Parameterised combinational 2-to-1 multiplexer: sel=0 picks a, sel=1 picks b.
module mux2_w #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 2:1 mux between sources A (x) and B (y),
// with a fairness hold limit under contention and a registered, valid-tagged output.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             s,
    output logic [WIDTH-1:0] m,
    output logic             m_valid
);

    localparam int               CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_b_q;
    logic             s_q;
    logic [WIDTH-1:0] mux_y;
    logic [WIDTH-1:0] m_p1;
    logic             vld_p1;

    // The counter only advances while the owner keeps requesting and the other side
    // is waiting; any state change leaves cnt_d at its cleared default.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (req_a && req_b)
                    state_d = last_b_q ? ARB_GNT_A : ARB_GNT_B;
                else if (req_a)
                    state_d = ARB_GNT_A;
                else if (req_b)
                    state_d = ARB_GNT_B;
            end
            ARB_GNT_A: begin
                if (!req_a)
                    state_d = req_b ? ARB_GNT_B : ARB_IDLE;
                else if (req_b) begin
                    if (cnt_q == CNT_LAST)
                        state_d = ARB_GNT_B;
                    else
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_GNT_B: begin
                if (!req_b)
                    state_d = req_a ? ARB_GNT_A : ARB_IDLE;
                else if (req_a) begin
                    if (cnt_q == CNT_LAST)
                        state_d = ARB_GNT_A;
                    else
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Control stage: grant state, hold counter, fairness pointer and select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            s_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= (state_d == ARB_GNT_B);
            if (state_d == ARB_GNT_A)
                last_b_q <= 1'b0;
            else if (state_d == ARB_GNT_B)
                last_b_q <= 1'b1;
        end
    end

    mux2_w #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a   (x),
        .b   (y),
        .sel (s_q),
        .y   (mux_y)
    );

    // Data stage: capture the selected source while a grant is active, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= (state_q != ARB_IDLE);
            if (state_q != ARB_IDLE)
                m_p1 <= mux_y;
        end
    end

    assign gnt_a   = (state_q == ARB_GNT_A);
    assign gnt_b   = (state_q == ARB_GNT_B);
    assign s       = s_q;
    assign m       = m_p1;
    assign m_valid = vld_p1;

endmodule
